// File: rtl/tlc_light_monitor.sv
// tlc_light_monitor: watches a highway/farm traffic-light pair, tracks the
// current phase and its dwell, counts completed light cycles and latches the
// first protocol violation into a sticky fault until clear_fault.
module tlc_light_monitor #(
  parameter int YEL_MIN   = 3,
  parameter int GRN_MIN   = 10,
  parameter int MAX_DWELL = 200   // must be <= 254 so MAX_DWELL+1 fits in dwell
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] light_highway,
  input  logic [2:0] light_farm,
  input  logic       clear_fault,
  output logic [2:0] phase,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] dwell,
  output logic       cycle_done,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_HG_FR = 3'd1,
    S_HY_FR = 3'd2,
    S_HR_FG = 3'd3,
    S_HR_FY = 3'd4,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [2:0] L_G = 3'b001;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_R = 3'b100;

  localparam logic [7:0] YEL_MIN_L   = YEL_MIN[7:0];
  localparam logic [7:0] GRN_MIN_L   = GRN_MIN[7:0];
  localparam logic [7:0] MAX_DWELL_L = MAX_DWELL[7:0];

  // Map a lamp pair to the phase it represents; S_SYNC means "not a phase".
  function automatic state_t decode(input logic [2:0] h, input logic [2:0] f);
    state_t s;
    case ({h, f})
      {L_G, L_R}: s = S_HG_FR;
      {L_Y, L_R}: s = S_HY_FR;
      {L_R, L_G}: s = S_HR_FG;
      {L_R, L_Y}: s = S_HR_FY;
      default:    s = S_SYNC;
    endcase
    return s;
  endfunction

  // The single legal successor of each phase.
  function automatic state_t next_of(input state_t s);
    state_t n;
    case (s)
      S_HG_FR: n = S_HY_FR;
      S_HY_FR: n = S_HR_FG;
      S_HR_FG: n = S_HR_FY;
      S_HR_FY: n = S_HG_FR;
      default: n = S_SYNC;
    endcase
    return n;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] fault_code_q, fault_code_d;
  logic [7:0] dwell_q, dwell_d;
  logic       cycle_done_q, cycle_done_d;
  logic [7:0] cycle_cnt_q, cycle_cnt_d;
  // Set while in the partial phase entered from SYNC; suppresses min-dwell checks.
  logic       first_q, first_d;

  state_t     dec, nxt;
  logic [2:0] fcode;

  // Fault detection for phase states; earlier branches are lower codes and win.
  always_comb begin
    dec   = decode(light_highway, light_farm);
    nxt   = next_of(state_q);
    fcode = 3'd0;
    if (!$onehot(light_highway) || !$onehot(light_farm))
      fcode = 3'd1;
    else if (light_highway != L_R && light_farm != L_R)
      fcode = 3'd2;
    else if (dec != S_SYNC && dec != state_q && dec != nxt)
      fcode = 3'd3;
    else if (dec == nxt && !first_q && (state_q == S_HY_FR || state_q == S_HR_FY)
             && dwell_q < YEL_MIN_L)
      fcode = 3'd4;
    else if (dec == nxt && !first_q && state_q == S_HR_FG && dwell_q < GRN_MIN_L)
      fcode = 3'd5;
    else if (dec != nxt && state_q != S_HG_FR && dwell_q == MAX_DWELL_L)
      fcode = 3'd6;
  end

  // Next-state, dwell, cycle accounting; everything holds when ena is low.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    dwell_d      = dwell_q;
    cycle_done_d = 1'b0;
    cycle_cnt_d  = cycle_cnt_q;
    first_d      = first_q;
    if (ena) begin
      case (state_q)
        S_SYNC: begin
          if (dec != S_SYNC) begin
            state_d = dec;
            dwell_d = 8'd1;
            first_d = 1'b1;
          end
        end
        S_FAULT: begin
          if (clear_fault) begin
            state_d      = S_SYNC;
            fault_code_d = 3'd0;
            dwell_d      = 8'd0;
          end
        end
        S_HG_FR, S_HY_FR, S_HR_FG, S_HR_FY: begin
          if (fcode != 3'd0) begin
            state_d      = S_FAULT;
            fault_code_d = fcode;
          end else if (dec == nxt) begin
            state_d = nxt;
            dwell_d = 8'd1;
            first_d = 1'b0;
            if (state_q == S_HR_FY) begin
              cycle_done_d = 1'b1;
              cycle_cnt_d  = cycle_cnt_q + 8'd1;
            end
          end else if (dwell_q != 8'hFF) begin
            // Same phase (or an all-red gap): keep counting, saturating.
            dwell_d = dwell_q + 8'd1;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  // State register with asynchronous reset to a blank SYNC monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SYNC;
      fault_code_q <= 3'd0;
      dwell_q      <= 8'd0;
      cycle_done_q <= 1'b0;
      cycle_cnt_q  <= 8'd0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      dwell_q      <= dwell_d;
      cycle_done_q <= cycle_done_d;
      cycle_cnt_q  <= cycle_cnt_d;
      first_q      <= first_d;
    end
  end

  assign phase      = state_q;
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fault_code_q;
  assign dwell      = dwell_q;
  assign cycle_done = cycle_done_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_tlc_light_monitor.sv
// Bench for tlc_light_monitor: a behavioural model pushes expected outputs per
// sample; each scenario task drains and compares them and adds spot checks.
module tb_tlc_light_monitor;
  localparam int YEL = 3, GRN = 10, MAXD = 200;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, clear_fault = 1'b0;
  logic [2:0] light_highway = 3'b0, light_farm = 3'b0;
  logic [2:0] phase, fault_code;
  logic       fault, cycle_done;
  logic [7:0] dwell, cycle_cnt;

  int total = 0, bad = 0;
  logic [23:0] exp_q[$], got_q[$];

  // model state
  logic [2:0] m_st, m_code;
  logic       m_done, m_first;
  int         m_dwell;
  logic [7:0] m_cnt;

  tlc_light_monitor #(.YEL_MIN(YEL), .GRN_MIN(GRN), .MAX_DWELL(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .light_highway(light_highway),
    .light_farm(light_farm), .clear_fault(clear_fault), .phase(phase),
    .fault(fault), .fault_code(fault_code), .dwell(dwell),
    .cycle_done(cycle_done), .cycle_cnt(cycle_cnt));

  always #5 clk = ~clk;

  function automatic logic [5:0] lamps(input int p);
    case (p)
      1: return {3'b001, 3'b100};
      2: return {3'b010, 3'b100};
      3: return {3'b100, 3'b001};
      4: return {3'b100, 3'b010};
      default: return 6'b0;
    endcase
  endfunction

  function automatic logic [2:0] mdec(input logic [2:0] h, input logic [2:0] f);
    for (int p = 1; p <= 4; p++) if ({h, f} == lamps(p)) return 3'(p);
    return 3'd0;
  endfunction

  function automatic logic [23:0] dut_out();
    return {phase, fault, fault_code, dwell, cycle_done, cycle_cnt};
  endfunction

  function automatic logic [23:0] model_out();
    return {m_st, (m_st == 3'd7), m_code, 8'(m_dwell), m_done, m_cnt};
  endfunction

  task automatic model_reset();
    m_st = 0; m_code = 0; m_done = 0; m_first = 0; m_dwell = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [2:0] h, input logic [2:0] f,
                            input logic clr, input logic e);
    logic [2:0] p, nxt, code;
    m_done = 0;
    if (!e) return;
    if (m_st == 3'd7) begin
      if (clr) begin m_st = 0; m_code = 0; m_dwell = 0; end
      return;
    end
    p = mdec(h, f);
    if (m_st == 3'd0) begin
      if (p != 0) begin m_st = p; m_dwell = 1; m_first = 1; end
      return;
    end
    nxt  = (m_st == 3'd4) ? 3'd1 : m_st + 3'd1;
    code = 0;
    if (!$onehot(h) || !$onehot(f)) code = 1;
    else if (h != 3'b100 && f != 3'b100) code = 2;
    else if (p != 0 && p != m_st && p != nxt) code = 3;
    else if (p == nxt && !m_first && (m_st == 2 || m_st == 4) && m_dwell < YEL) code = 4;
    else if (p == nxt && !m_first && m_st == 3 && m_dwell < GRN) code = 5;
    else if (p != nxt && m_st != 1 && m_dwell == MAXD) code = 6;
    if (code != 0) begin m_st = 7; m_code = code; return; end
    if (p == nxt) begin
      if (m_st == 3'd4) begin m_done = 1; m_cnt = m_cnt + 8'd1; end
      m_st = p; m_dwell = 1; m_first = 0;
    end else if (m_dwell < 255) m_dwell++;
  endtask

  task automatic do_reset();
    rst_n = 0; ena = 1; clear_fault = 0; light_highway = 0; light_farm = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic step(input logic [2:0] h, input logic [2:0] f,
                      input logic clr, input logic e);
    light_highway = h; light_farm = f; clear_fault = clr; ena = e;
    model_step(h, f, clr, e);
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    got_q.push_back(dut_out());
  endtask

  task automatic run_phase(input int p, input int n);
    logic [5:0] lf;
    lf = lamps(p);
    for (int i = 0; i < n; i++) step(lf[5:3], lf[2:0], 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 0; #1;
    total++;
    if (dut_out() !== 24'h0) begin bad++; $display("FAIL reset_state got=%h exp=0", dut_out()); end
    do_reset();
  endtask

  task automatic test_legal_cycle();
    logic [2:0] prev; logic [14:0] seq, seq_exp; int nseq, dones;
    logic [23:0] e, g;
    do_reset();
    prev = phase; seq = 0; nseq = 0;
    run_phase(1, 5); run_phase(2, 3); run_phase(3, 10); run_phase(4, 3); run_phase(1, 1);
    dones = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL legal_step got=%h exp=%h", g, e); end
      if (g[23:21] != prev) begin seq = {seq[11:0], g[23:21]}; nseq++; prev = g[23:21]; end
      dones += int'(g[8]);
    end
    seq_exp = {3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    total++;
    if (seq !== seq_exp || nseq != 5) begin bad++; $display("FAIL legal_seq got=%h/%0d exp=%h/5", seq, nseq, seq_exp); end
    total++;
    if (dones != 1 || cycle_cnt !== 8'd1 || fault !== 1'b0) begin
      bad++; $display("FAIL legal_count got done=%0d cnt=%0d fault=%b exp 1/1/0", dones, cycle_cnt, fault);
    end
  endtask

  task automatic test_short_yellow();
    logic [23:0] e, g;
    do_reset();
    run_phase(1, 2); run_phase(2, 2); run_phase(3, 1);
    total++;
    if ({phase, fault, fault_code} !== {3'd7, 1'b1, 3'd4}) begin
      bad++; $display("FAIL short_yellow got=%0d/%b/%0d exp 7/1/4", phase, fault, fault_code);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL short_yellow_step got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_conflict();
    logic [23:0] e, g;
    do_reset();
    run_phase(1, 2);
    step(3'b001, 3'b001, 1'b0, 1'b1);
    total++;
    if ({phase, fault_code} !== {3'd7, 3'd2}) begin bad++; $display("FAIL conflict got=%0d/%0d exp 7/2", phase, fault_code); end
    step(3'b011, 3'b001, 1'b0, 1'b1);
    total++;
    if (fault_code !== 3'd2) begin bad++; $display("FAIL conflict_sticky got=%0d exp=2", fault_code); end
    step(3'b001, 3'b100, 1'b1, 1'b1);
    total++;
    if ({phase, fault, fault_code, dwell} !== 15'd0) begin
      bad++; $display("FAIL conflict_clear got=%0d/%b/%0d/%0d exp 0/0/0/0", phase, fault, fault_code, dwell);
    end
    // clear_fault in a phase does nothing; a fault alongside it still latches
    run_phase(1, 1);
    step(3'b001, 3'b100, 1'b1, 1'b1);
    step(3'b001, 3'b001, 1'b1, 1'b1);
    total++;
    if ({phase, fault_code} !== {3'd7, 3'd2}) begin bad++; $display("FAIL clear_same_cycle got=%0d/%0d exp 7/2", phase, fault_code); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL conflict_step got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_illegal();
    logic [23:0] e, g;
    do_reset();
    run_phase(1, 2);
    step(3'b100, 3'b001, 1'b0, 1'b1);
    total++;
    if (fault_code !== 3'd3) begin bad++; $display("FAIL illegal_jump got=%0d exp=3", fault_code); end
    step(3'b000, 3'b000, 1'b1, 1'b1);
    run_phase(1, 2);
    step(3'b000, 3'b001, 1'b0, 1'b1);
    total++;
    if (fault_code !== 3'd1) begin bad++; $display("FAIL priority got=%0d exp=1", fault_code); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL illegal_step got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_watchdog();
    logic [23:0] e, g;
    do_reset();
    run_phase(1, 1); run_phase(2, 3); run_phase(3, 200);
    total++;
    if ({phase, fault, dwell} !== {3'd3, 1'b0, 8'd200}) begin
      bad++; $display("FAIL watchdog_pre got=%0d/%b/%0d exp 3/0/200", phase, fault, dwell);
    end
    run_phase(3, 1);
    total++;
    if ({phase, fault_code, dwell} !== {3'd7, 3'd6, 8'd200}) begin
      bad++; $display("FAIL watchdog got=%0d/%0d/%0d exp 7/6/200", phase, fault_code, dwell);
    end
    do_reset();
    run_phase(1, 300);
    total++;
    if ({phase, fault, dwell} !== {3'd1, 1'b0, 8'd255}) begin
      bad++; $display("FAIL hg_saturate got=%0d/%b/%0d exp 1/0/255", phase, fault, dwell);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL watchdog_step got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] e, g; int dones;
    do_reset();
    run_phase(1, 1);
    for (int c = 0; c < 256; c++) begin
      run_phase(2, 3); run_phase(3, 10); run_phase(4, 3); run_phase(1, 1);
    end
    dones = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      dones += int'(g[8]);
      if (g !== e) begin bad++; $display("FAIL wrap_step got=%h exp=%h", g, e); end
    end
    total++;
    if (cycle_cnt !== 8'd0 || dones != 256 || fault !== 1'b0) begin
      bad++; $display("FAIL wrap got cnt=%0d done=%0d fault=%b exp 0/256/0", cycle_cnt, dones, fault);
    end
  endtask

  task automatic test_ena();
    logic [23:0] e, g;
    do_reset();
    run_phase(1, 2); run_phase(2, 2);
    for (int i = 0; i < 20; i++) step(3'($urandom), 3'($urandom), 1'($urandom), 1'b0);
    total++;
    if ({phase, dwell, cycle_done} !== {3'd2, 8'd2, 1'b0}) begin
      bad++; $display("FAIL ena_hold got=%0d/%0d/%b exp 2/2/0", phase, dwell, cycle_done);
    end
    run_phase(2, 1);
    total++;
    if (dwell !== 8'd3) begin bad++; $display("FAIL ena_resume got=%0d exp=3", dwell); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL ena_step got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] e, g;
    do_reset();
    run_phase(1, 1); run_phase(2, 3); run_phase(3, 10); run_phase(4, 3); run_phase(1, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL async_pre_step got=%h exp=%h", g, e); end
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (dut_out() !== 24'h0) begin bad++; $display("FAIL async_reset got=%h exp=0", dut_out()); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    run_phase(3, 1);
    total++;
    if ({phase, dwell, cycle_cnt} !== {3'd3, 8'd1, 8'd0}) begin
      bad++; $display("FAIL resync got=%0d/%0d/%0d exp 3/1/0", phase, dwell, cycle_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL resync_step got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e, g; logic [5:0] lf; int p, n, len;
    do_reset();
    p = 1; n = 0; len = $urandom_range(1, 12);
    for (int i = 0; i < 800; i++) begin
      lf = ($urandom_range(0, 11) == 0) ? 6'($urandom) : lamps(p);
      step(lf[5:3], lf[2:0], ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0));
      n++;
      if (n >= len) begin p = (p % 4) + 1; n = 0; len = $urandom_range(1, 14); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL random_step got=%h exp=%h", g, e); end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_legal_cycle();
    test_short_yellow();
    test_conflict();
    test_illegal();
    test_watchdog();
    test_wrap();
    test_ena();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
